divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand/result width; only 64 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 The block SHALL have port div_valid, input, 1, request from the control unit, held high until done.
REQ-005 The block SHALL have port div_sign, input, 1, 1 = signed (div/rem/divw/remw), 0 = unsigned.
REQ-006 The block SHALL have port div_w, input, 1, 1 = 32-bit word op (divw/divuw/remw/remuw).
REQ-007 The block SHALL have port a, input, XLEN, dividend (rs1).
REQ-008 The block SHALL have port b, input, XLEN, divisor (rs2).
REQ-009 The block SHALL have port busy, output, 1, high while a division is in progress; the CPU stalls the PC on busy.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse when quot/rem are valid.
REQ-011 The block SHALL have port quot, output, XLEN, quotient; the writeback mux selects it for m2reg=101.
REQ-012 The block SHALL have port rem, output, XLEN, remainder; the writeback mux selects it for m2reg=110.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 In IDLE with div_valid=1, the block SHALL capture operands, sign, and w on that edge and go to BUSY; busy=1 from the next cycle.
REQ-015 In BUSY, the block SHALL run one restoring radix-2 iteration per cycle on operand magnitudes, 64 iterations (XLEN mode) or 32 (w mode), counted by an iteration counter.
REQ-016 After the last iteration, the block SHALL enter DONE for exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-017 Latency SHALL be done asserted in cycle N+1 after the accept edge, with N=64 or 32.
REQ-018 quot/rem SHALL stay stable from DONE until the next accept; done SHALL NOT be asserted in any other state.
REQ-019 A div_valid still high in the IDLE cycle after DONE SHALL be treated as a new request (back-to-back divides).
REQ-020 If div_valid drops during BUSY, the block SHALL abort to IDLE on the next edge, with no done and quot/rem unchanged.
REQ-021 In w mode, operands SHALL be a[31:0] and b[31:0], sign-extended if div_sign=1, else zero-extended; 32-bit results SHALL be sign-extended to 64 bits, divuw/remuw included.
REQ-022 Signed operation SHALL divide magnitudes; quot is negated if the operand signs differ, and rem takes the sign of the dividend (truncating division).
REQ-023 For divisor zero: quot = all ones, rem = dividend (w mode: the extended 32-bit dividend, then sign-extended).
REQ-024 For signed overflow (dividend = most-negative of the operating width, divisor = -1): quot = dividend, rem = 0.
REQ-025 busy SHALL be 1 only in BUSY.

Reset
REQ-026 reset low SHALL immediately force IDLE, iteration counter 0, busy=0, done=0, quot=0, rem=0, and all internal registers 0.
REQ-027 Reset asserted mid-division SHALL discard the operation; after release the block SHALL accept a new request from IDLE.

Configuration
REQ-028 With macro DIV_FASTPATH_EN defined, divisor-zero and signed-overflow cases SHALL skip BUSY: accept -> DONE next cycle (latency 1).
REQ-029 Without DIV_FASTPATH_EN, those cases SHALL take the full N-cycle path, and the REQ-023/REQ-024 results SHALL be applied at DONE.
REQ-030 Results SHALL be identical with and without DIV_FASTPATH_EN; only latency differs.

Verification
REQ-031 Bench SHALL cover: unsigned, a=100, b=7 -> quot=14, rem=2, done exactly 65 cycles after accept, busy high for 64 cycles.
REQ-032 Bench SHALL cover: signed, a=-7, b=2 -> quot=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1.
REQ-033 Bench SHALL cover: w, unsigned, a=0xFFFF_FFFF_8000_0000, b=1 -> quot=0xFFFF_FFFF_8000_0000, rem=0, done 33 cycles after accept.
REQ-034 Bench SHALL cover: signed, b=0, a=5 -> quot=all ones, rem=5; signed a=0x8000_0000_0000_0000, b=-1 -> quot=a, rem=0; latency 1 with DIV_FASTPATH_EN, 65 without.
REQ-035 Bench SHALL cover: div_valid dropped at BUSY cycle 10 -> IDLE next cycle, no done; reset pulsed at BUSY cycle 20 -> all outputs 0 immediately.
REQ-036 Bench SHALL cover: div_valid held high across two back-to-back requests -> two done pulses 66 cycles apart (64-bit mode).

Source files
------------

// File: rtl/divider.sv
// Multi-cycle restoring radix-2 divider for RV64M div/rem (64-bit and 32-bit word forms).
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow finish one cycle after accept.
module divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_valid,
  input  logic            div_sign,
  input  logic            div_w,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic [1:0]      dbg_state
);

  localparam int HALF = XLEN / 2;

  // Handshake: div_valid is a level request held until done; dropping it while busy aborts.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [5:0]      r_cnt;
  logic            r_w;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic            r_ovf;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_quot_o;
  logic [XLEN-1:0] r_rem_o;

  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] x, input logic w);
    fix_w = w ? {{HALF{x[HALF-1]}}, x[HALF-1:0]} : x;
  endfunction

  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_min;
  logic            w_dz;
  logic            w_ovf;

  // Word ops see only the low half, extended according to signedness.
  assign w_op_a  = div_w ? {{HALF{div_sign & a[HALF-1]}}, a[HALF-1:0]} : a;
  assign w_op_b  = div_w ? {{HALF{div_sign & b[HALF-1]}}, b[HALF-1:0]} : b;
  assign w_neg_a = div_sign & w_op_a[XLEN-1];
  assign w_neg_b = div_sign & w_op_b[XLEN-1];
  assign w_mag_a = w_neg_a ? (~w_op_a + 1'b1) : w_op_a;
  assign w_mag_b = w_neg_b ? (~w_op_b + 1'b1) : w_op_b;
  assign w_min   = div_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_dz    = (w_op_b == '0);
  assign w_ovf   = div_sign & (w_op_b == '1) & (w_op_a == w_min);

  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_q_s;
  logic [XLEN-1:0] w_r_s;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [5:0]      w_last;

  // The partial remainder stays below the divisor, so the trial subtraction fits in XLEN bits.
  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_ge     = (w_shift >= {1'b0, r_div});
  assign w_rem_nx = w_shift[XLEN-1:0] - (w_ge ? r_div : '0);
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};
  assign w_q_s    = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_r_s    = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
  assign w_q_fin  = r_dz ? '1 : (r_ovf ? fix_w(r_op_a, r_w) : fix_w(w_q_s, r_w));
  assign w_r_fin  = r_dz ? fix_w(r_op_a, r_w) : (r_ovf ? '0 : fix_w(w_r_s, r_w));
  assign w_last   = r_w ? 6'd31 : 6'd63;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_w      <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_op_a   <= '0;
      r_div    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (div_valid) begin
            r_cnt   <= '0;
            r_w     <= div_w;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf;
            r_op_a  <= w_op_a;
            r_div   <= w_mag_b;
            // Word ops pre-shift the dividend so 32 iterations consume exactly its low half.
            r_quo   <= div_w ? {w_mag_a[HALF-1:0], {HALF{1'b0}}} : w_mag_a;
            r_rem   <= '0;
`ifdef DIV_FASTPATH_EN
            if (w_dz || w_ovf) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_quot_o <= w_dz ? '1 : fix_w(w_op_a, div_w);
              r_rem_o  <= w_dz ? fix_w(w_op_a, div_w) : '0;
            end else begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
            end
`else
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
`endif
          end
        end
        S_BUSY: begin
          if (!div_valid) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == w_last) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_quot_o <= w_q_fin;
              r_rem_o  <= w_r_fin;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quot      = r_quot_o;
  assign rem       = r_rem_o;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: reference-model scoreboard plus latency, abort and reset checks.
module tb_divider;

  logic        clk;
  logic        reset;
  logic        div_valid;
  logic        div_sign;
  logic        div_w;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] quot;
  logic [63:0] rem;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];
  logic [63:0]  last_q;
  logic [63:0]  last_r;

`ifdef DIV_FASTPATH_EN
  localparam int SPECIAL_FAST = 1;
`else
  localparam int SPECIAL_FAST = 0;
`endif

  divider #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .div_valid(div_valid), .div_sign(div_sign), .div_w(div_w),
    .a(a), .b(b), .busy(busy), .done(done), .quot(quot), .rem(rem), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%h exp=0x%h", name, act, exp);
    end
  endtask

  // Reference: plain truncating division with the RISC-V corner-case rules.
  function automatic logic [127:0] ref_div(input logic sgn, input logic w,
                                           input logic [63:0] x, input logic [63:0] y);
    logic [63:0] q, r;
    logic [31:0] x32, y32, q32, r32;
    x32 = x[31:0];
    y32 = y[31:0];
    if (w) begin
      if (y32 == 32'd0) begin q32 = '1; r32 = x32; end
      else if (sgn && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) begin q32 = x32; r32 = '0; end
      else if (sgn) begin q32 = $signed(x32) / $signed(y32); r32 = $signed(x32) % $signed(y32); end
      else begin q32 = x32 / y32; r32 = x32 % y32; end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (y == 64'd0) begin q = '1; r = x; end
      else if (sgn && x == 64'h8000_0000_0000_0000 && y == '1) begin q = x; r = '0; end
      else if (sgn) begin q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); end
      else begin q = x / y; r = x % y; end
    end
    return {q, r};
  endfunction

  function automatic int ref_lat(input logic sgn, input logic w,
                                 input logic [63:0] x, input logic [63:0] y);
    logic special;
    if (w) special = (y[31:0] == 32'd0) || (sgn && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
    else   special = (y == 64'd0) || (sgn && x == 64'h8000_0000_0000_0000 && y == '1);
    if (special && SPECIAL_FAST == 1) return 1;
    return w ? 33 : 65;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && done) begin
      logic [127:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("quot", quot, e[127:64]);
        check("rem", rem, e[63:0]);
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  // driver: full request, held until done, with latency and busy-length checks
  task automatic run_div(input logic sgn, input logic w, input logic [63:0] x, input logic [63:0] y);
    int c, nb, lat;
    logic [127:0] e;
    e = ref_div(sgn, w, x, y);
    lat = ref_lat(sgn, w, x, y);
    exp_q.push_back(e);
    @(negedge clk);
    div_sign = sgn; div_w = w; a = x; b = y; div_valid = 1'b1;
    @(posedge clk);
    c = 0; nb = 0;
    do begin
      @(negedge clk);
      c++;
      if (busy) nb++;
    end while (!done && c < 200);
    check("latency", 64'(c), 64'(lat));
    check("busy_cycles", 64'(nb), 64'(lat - 1));
    div_valid = 1'b0;
    last_q = e[127:64];
    last_r = e[63:0];
    @(negedge clk);
  endtask

  initial begin
    div_valid = 1'b0; div_sign = 1'b0; div_w = 1'b0; a = '0; b = '0;
    last_q = '0; last_r = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_quot", quot, 64'd0);
    check("rst_rem", rem, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_div(1'b0, 1'b0, 64'd100, 64'd7);
    run_div(1'b1, 1'b0, -64'sd7, 64'd2);
    run_div(1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1);
    run_div(1'b1, 1'b0, 64'd5, 64'd0);
    run_div(1'b1, 1'b0, 64'h8000_0000_0000_0000, '1);
    run_div(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0);
    run_div(1'b0, 1'b1, 64'hDEAD_BEEF_8765_4321, 64'hFFFF_FFFF_0000_0000);
    run_div(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    run_div(1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);

    // abort: drop div_valid in BUSY cycle 10
    begin
      int c;
      @(negedge clk);
      div_sign = 1'b0; div_w = 1'b0; a = 64'd999_999; b = 64'd13; div_valid = 1'b1;
      @(posedge clk);
      c = 0;
      do begin @(negedge clk); c++; end while (c < 10);
      check("abort_busy_before", {63'd0, busy}, 64'd1);
      div_valid = 1'b0;
      @(negedge clk);
      check("abort_busy_after", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_quot_kept", quot, last_q);
      check("abort_rem_kept", rem, last_r);
      repeat (70) @(negedge clk);
    end

    // reset pulse in BUSY cycle 20
    begin
      int c;
      @(negedge clk);
      div_sign = 1'b1; div_w = 1'b0; a = 64'd123_456_789; b = -64'sd321; div_valid = 1'b1;
      @(posedge clk);
      c = 0;
      do begin @(negedge clk); c++; end while (c < 20);
      div_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("rstmid_busy", {63'd0, busy}, 64'd0);
      check("rstmid_done", {63'd0, done}, 64'd0);
      check("rstmid_quot", quot, 64'd0);
      check("rstmid_rem", rem, 64'd0);
      #2;
      reset = 1'b1;
      last_q = '0; last_r = '0;
      repeat (2) @(negedge clk);
    end
    run_div(1'b0, 1'b0, 64'd1000, 64'd10);

    // back-to-back with div_valid held high
    begin
      int c, t1, t2;
      exp_q.push_back(ref_div(1'b0, 1'b0, 64'd77, 64'd5));
      exp_q.push_back(ref_div(1'b1, 1'b0, -64'sd1000, 64'd33));
      @(negedge clk);
      div_sign = 1'b0; div_w = 1'b0; a = 64'd77; b = 64'd5; div_valid = 1'b1;
      @(posedge clk);
      c = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && c < 400) begin
        @(negedge clk);
        c++;
        if (done) begin
          if (t1 < 0) begin
            t1 = c;
            div_sign = 1'b1; a = -64'sd1000; b = 64'd33;
          end else t2 = c;
        end
      end
      check("b2b_first_latency", 64'(t1), 64'd65);
      check("b2b_gap", 64'(t2 - t1), 64'd66);
      div_valid = 1'b0;
      @(negedge clk);
    end

    // randomized
    for (int i = 0; i < 24; i++) begin
      logic        s, w;
      logic [63:0] x, y;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom} >> $urandom_range(0, 63);
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin
          y = '1;
          x = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          s = 1'b1;
        end
        default: ;
      endcase
      run_div(s, w, x, y);
    end

    repeat (5) @(negedge clk);
    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
